pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed 32-bit IF/ID latch: a generic pipeline stage register carrying an instruction/payload word plus its address.
- Adds a valid/ready handshake and a one-entry skid buffer, so upstream ready is fully registered.
- Keeps the existing stall (hazardDetected_i) and flush (IFFlush_i) semantics.
- Instantiated between any two pipeline stages (IF/ID first, then ID/EX) in place of hand-written stage registers.

Parameters:
- DATA_W, 32, width of the instruction/payload word.
- ADDR_W, 32, width of the associated address.
- FLUSH_VAL, {DATA_W{1'b0}}, payload value driven when the stage is empty or flushed (e.g. 32'h00000013 for a NOP bubble).

Ports:
- clk_i  in  1  single clock; all state updates on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  upstream beat valid.
- ready_o  out  1  stage can accept a beat this cycle.
- instr_i  in  DATA_W  upstream payload.
- instrAddr_i  in  ADDR_W  upstream address.
- hazardDetected_i  in  1  stall: hold the output beat and accept no transfer downstream.
- IFFlush_i  in  1  flush: discard all held beats and any incoming beat.
- valid_o  out  1  output beat valid.
- ready_i  in  1  downstream accepts the beat.
- instr_o  out  DATA_W  output payload (registered).
- instrAddr_o  out  ADDR_W  output address (registered).

Behaviour:
- Storage: output register (out_v, instr_o, instrAddr_o) plus skid register (skid_v, skid_d, skid_a).
- State is encoded by {out_v, skid_v}: EMPTY=00, ONE=10, TWO=11. The value 01 is illegal and must never occur.
- Definitions: take = valid_i & ready_o; give = out_v & ready_i & ~hazardDetected_i.
- ready_o = ~skid_v & ~rst_i. It depends only on a flop and rst_i, never on ready_i.
- Reset (rst_i high at edge):
  - valid_o=0, skid_v=0.
  - instr_o=FLUSH_VAL, instrAddr_o=0; skid contents = FLUSH_VAL/0.
  - Inputs are ignored, and reset overrides flush and stall.
  - A beat in flight when reset asserts is lost.
- Flush (IFFlush_i high, no reset):
  - Next state EMPTY; instr_o=FLUSH_VAL, instrAddr_o=0.
  - The beat offered that cycle is dropped even if ready_o=1.
  - Flush has priority over stall.
- Transitions (no reset, no flush):
  - EMPTY: if take, load out from inputs -> ONE; otherwise stay.
  - ONE, take & give: load out from inputs -> ONE.
  - ONE, take & ~give: load skid from inputs -> TWO.
  - ONE, ~take & give: -> EMPTY; payload is set to FLUSH_VAL/0.
  - ONE, ~take & ~give: hold.
  - TWO (ready_o=0, so take=0): if give, move skid into out, clear skid_v -> ONE; otherwise hold.
- Latency: 1 cycle from take to valid_o when the stage is EMPTY or draining. Throughput is 1 beat/cycle with ready_i held high.
- Output payload is stable while valid_o=1 and no give occurs (AXI-style hold rule).
- Stall while EMPTY has no effect on accepting one beat.
- No beat is ever duplicated or reordered; FIFO order is preserved through the skid register.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- Defined: adds outputs stallCnt_o[15:0] and flushCnt_o[15:0].
  - stallCnt_o increments each cycle with out_v & hazardDetected_i.
  - flushCnt_o increments each cycle with IFFlush_i & (out_v | skid_v | valid_i).
  - Both saturate at 16'hFFFF and clear on rst_i.
- Undefined: these ports and counters do not exist, and the functional behaviour above is unchanged.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles -> valid_o=0, ready_o=0 during reset, instr_o=FLUSH_VAL; after release ready_o=1.
- Streaming with ready_i=1: 8 beats instr=0x100..0x107, addr=0x0..0x1C -> valid_o rises 1 cycle after the first take; beats appear in order, one per cycle, with no gaps.
- Backpressure into skid: beat A (0xAAAA) then beat B (0xBBBB), with ready_i=0 from the cycle after A -> state TWO, ready_o=0, instr_o=0xAAAA holds. Release ready_i -> A then B delivered and ready_o returns to 1.
- Stall: state ONE holding 0x1234, hazardDetected_i=1 for 3 cycles with ready_i=1 -> instr_o=0x1234, valid_o=1 unchanged. Deassert -> delivered next edge.
- Flush in TWO with valid_i=1 (0xCCCC): IFFlush_i for 1 cycle -> next cycle valid_o=0, instr_o=FLUSH_VAL, ready_o=1; 0xCCCC is never output.
- Flush+stall+reset same cycle: all asserted -> reset values result. With PIPE_STAGE_STATS_EN: 70000 stalled cycles -> stallCnt_o=16'hFFFF.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic pipeline stage register with a valid/ready
// handshake and a one-entry skid buffer. It replaces the fixed IF/ID latch
// and can sit between any two pipeline stages.
//
// Because of the skid buffer, upstream ready_o comes only from a flop (and
// rst_i). It never depends on the downstream ready_i.
//
// Ports:
//   clk_i            clock; all state updates on its rising edge
//   rst_i            synchronous, active-high reset
//   valid_i/ready_o  upstream handshake
//   instr_i          upstream payload       [DATA_W]
//   instrAddr_i      upstream address       [ADDR_W]
//   hazardDetected_i stall: hold the output beat, no downstream transfer
//   IFFlush_i        flush: drop held beats and the incoming beat
//   valid_o/ready_i  downstream handshake
//   instr_o          registered payload     [DATA_W]
//   instrAddr_o      registered address     [ADDR_W]
//
// Optional feature (macro PIPE_STAGE_STATS_EN):
//   stallCnt_o[15:0]  cycles with a held beat under stall (saturating)
//   flushCnt_o[15:0]  flush cycles that discarded something (saturating)
// With the macro undefined these ports and counters are absent.

module pipe_stage_skid #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter logic [DATA_W-1:0] FLUSH_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] instr_i,
    input  logic [ADDR_W-1:0] instrAddr_i,
    input  logic              hazardDetected_i,
    input  logic              IFFlush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] instrAddr_o
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [15:0]       stallCnt_o,
    output logic [15:0]       flushCnt_o
`endif
);

    logic              out_v;
    logic              skid_v;
    logic [DATA_W-1:0] skid_d;
    logic [ADDR_W-1:0] skid_a;
    logic              take;
    logic              give;

    assign ready_o = ~skid_v & ~rst_i;
    assign valid_o = out_v;
    assign take    = valid_i & ready_o;
    assign give    = out_v & ready_i & ~hazardDetected_i;

    // {out_v, skid_v}: 00 empty, 10 one beat, 11 two beats; 01 never occurs.
    always_ff @(posedge clk_i) begin
        if (rst_i || IFFlush_i) begin
            out_v       <= 1'b0;
            skid_v      <= 1'b0;
            instr_o     <= FLUSH_VAL;
            instrAddr_o <= '0;
            skid_d      <= FLUSH_VAL;
            skid_a      <= '0;
        end else begin
            case ({out_v, skid_v})
                2'b00: begin
                    if (take) begin
                        out_v       <= 1'b1;
                        instr_o     <= instr_i;
                        instrAddr_o <= instrAddr_i;
                    end
                end
                2'b10: begin
                    if (take && give) begin
                        instr_o     <= instr_i;
                        instrAddr_o <= instrAddr_i;
                    end else if (take) begin
                        // Downstream is busy: park the new beat behind the held one.
                        skid_v <= 1'b1;
                        skid_d <= instr_i;
                        skid_a <= instrAddr_i;
                    end else if (give) begin
                        out_v       <= 1'b0;
                        instr_o     <= FLUSH_VAL;
                        instrAddr_o <= '0;
                    end
                end
                2'b11: begin
                    // ready_o is low here, so only draining is possible.
                    if (give) begin
                        skid_v      <= 1'b0;
                        instr_o     <= skid_d;
                        instrAddr_o <= skid_a;
                        skid_d      <= FLUSH_VAL;
                        skid_a      <= '0;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to empty.
                    out_v       <= 1'b0;
                    skid_v      <= 1'b0;
                    instr_o     <= FLUSH_VAL;
                    instrAddr_o <= '0;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stallCnt_o <= '0;
            flushCnt_o <= '0;
        end else begin
            if (out_v && hazardDetected_i && stallCnt_o != 16'hFFFF)
                stallCnt_o <= stallCnt_o + 16'd1;
            if (IFFlush_i && (out_v || skid_v || valid_i) && flushCnt_o != 16'hFFFF)
                flushCnt_o <= flushCnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

    localparam logic [31:0] FV = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] instr_i = '0;
    logic [31:0] instrAddr_i = '0;
    logic        hazardDetected_i = 1'b0;
    logic        IFFlush_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] instrAddr_o;
`ifdef PIPE_STAGE_STATS_EN
    logic [15:0] stallCnt_o;
    logic [15:0] flushCnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] sb_q[$];

    pipe_stage_skid #(.DATA_W(32), .ADDR_W(32), .FLUSH_VAL(FV)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .instr_i(instr_i), .instrAddr_i(instrAddr_i),
        .hazardDetected_i(hazardDetected_i), .IFFlush_i(IFFlush_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .instr_o(instr_o), .instrAddr_o(instrAddr_o)
`ifdef PIPE_STAGE_STATS_EN
        , .stallCnt_o(stallCnt_o), .flushCnt_o(flushCnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [31:0] a);
        valid_i     = v;
        instr_i     = d;
        instrAddr_i = a;
    endtask

    // Scoreboard: delivered beats are compared against the queue of accepted
    // beats; the queue is pushed on every accepted beat and cleared on
    // flush/reset, since those discard everything held.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst_i && !IFFlush_i && valid_o && ready_i && !hazardDetected_i) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_beat", {instrAddr_o, instr_o}, 64'hDEAD);
            end else begin
                e = sb_q.pop_front();
                chk("beat_instr", {32'h0, instr_o}, {32'h0, e[31:0]});
                chk("beat_addr", {32'h0, instrAddr_o}, {32'h0, e[63:32]});
            end
        end
        if (rst_i || IFFlush_i)
            sb_q.delete();
        else if (valid_i && ready_o)
            sb_q.push_back({instrAddr_i, instr_i});
    end

    initial begin
        // Reset for two cycles
        step();
        step();
        chk("rst_valid", {63'h0, valid_o}, 64'h0);
        chk("rst_ready", {63'h0, ready_o}, 64'h0);
        chk("rst_instr", {32'h0, instr_o}, {32'h0, FV});
        chk("rst_addr", {32'h0, instrAddr_o}, 64'h0);
        rst_i = 1'b0;
        step();
        chk("idle_ready", {63'h0, ready_o}, 64'h1);
        chk("idle_valid", {63'h0, valid_o}, 64'h0);

        // Streaming, ready_i high: one beat per cycle, one cycle latency
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h100 + i, 32'(4 * i));
            step();
            chk("stream_valid", {63'h0, valid_o}, 64'h1);
            chk("stream_instr", {32'h0, instr_o}, {32'h0, 32'h100 + i});
            chk("stream_ready", {63'h0, ready_o}, 64'h1);
        end
        drive(1'b0, '0, '0);
        step();
        chk("drain_valid", {63'h0, valid_o}, 64'h0);
        chk("drain_instr", {32'h0, instr_o}, {32'h0, FV});

        // Backpressure into the skid register
        drive(1'b1, 32'hAAAA, 32'h40);
        step();
        ready_i = 1'b0;
        drive(1'b1, 32'hBBBB, 32'h44);
        step();
        drive(1'b0, '0, '0);
        chk("two_ready", {63'h0, ready_o}, 64'h0);
        chk("two_instr", {32'h0, instr_o}, 64'hAAAA);
        step();
        chk("two_hold_instr", {32'h0, instr_o}, 64'hAAAA);
        chk("two_hold_valid", {63'h0, valid_o}, 64'h1);
        ready_i = 1'b1;
        step();
        chk("skid_out_instr", {32'h0, instr_o}, 64'hBBBB);
        chk("skid_out_addr", {32'h0, instrAddr_o}, 64'h44);
        chk("skid_out_ready", {63'h0, ready_o}, 64'h1);
        step();
        chk("skid_drain_valid", {63'h0, valid_o}, 64'h0);

        // Stall: empty stage still accepts, then holds for three cycles
        hazardDetected_i = 1'b1;
        drive(1'b1, 32'h1234, 32'h80);
        step();
        drive(1'b0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_instr", {32'h0, instr_o}, 64'h1234);
            chk("stall_valid", {63'h0, valid_o}, 64'h1);
            step();
        end
        hazardDetected_i = 1'b0;
        step();
        chk("stall_release_valid", {63'h0, valid_o}, 64'h0);

        // Flush while holding two beats, with a new beat offered
        ready_i = 1'b0;
        drive(1'b1, 32'hD1, 32'hC0);
        step();
        drive(1'b1, 32'hD2, 32'hC4);
        step();
        chk("pre_flush_ready", {63'h0, ready_o}, 64'h0);
        drive(1'b1, 32'hCCCC, 32'hC8);
        IFFlush_i = 1'b1;
        step();
        IFFlush_i = 1'b0;
        drive(1'b0, '0, '0);
        chk("flush_valid", {63'h0, valid_o}, 64'h0);
        chk("flush_instr", {32'h0, instr_o}, {32'h0, FV});
        chk("flush_addr", {32'h0, instrAddr_o}, 64'h0);
        chk("flush_ready", {63'h0, ready_o}, 64'h1);
        ready_i = 1'b1;
        step();
        chk("flush_no_ghost", {63'h0, valid_o}, 64'h0);

        // Flush drops a beat offered while ready_o is high
        drive(1'b1, 32'hEEEE, 32'hD0);
        IFFlush_i = 1'b1;
        step();
        IFFlush_i = 1'b0;
        drive(1'b0, '0, '0);
        chk("flush_drop_valid", {63'h0, valid_o}, 64'h0);

        // Reset, flush and stall together
        ready_i = 1'b0;
        drive(1'b1, 32'h5555, 32'hE0);
        step();
        rst_i = 1'b1;
        IFFlush_i = 1'b1;
        hazardDetected_i = 1'b1;
        drive(1'b1, 32'h6666, 32'hE4);
        step();
        chk("all_valid", {63'h0, valid_o}, 64'h0);
        chk("all_instr", {32'h0, instr_o}, {32'h0, FV});
        chk("all_addr", {32'h0, instrAddr_o}, 64'h0);
        chk("all_ready", {63'h0, ready_o}, 64'h0);
        rst_i = 1'b0;
        IFFlush_i = 1'b0;
        hazardDetected_i = 1'b0;
        drive(1'b0, '0, '0);
        step();
        chk("post_rst_ready", {63'h0, ready_o}, 64'h1);
        chk("post_rst_valid", {63'h0, valid_o}, 64'h0);

`ifdef PIPE_STAGE_STATS_EN
        chk("stats_stall_clr", {48'h0, stallCnt_o}, 64'h0);
        chk("stats_flush_clr", {48'h0, flushCnt_o}, 64'h0);
        ready_i = 1'b1;
        drive(1'b1, 32'h7777, 32'hF0);
        step();
        drive(1'b0, '0, '0);
        hazardDetected_i = 1'b1;
        for (int i = 0; i < 70000; i++) step();
        chk("stats_stall_sat", {48'h0, stallCnt_o}, 64'hFFFF);
        hazardDetected_i = 1'b0;
        IFFlush_i = 1'b1;
        step();
        IFFlush_i = 1'b0;
        chk("stats_flush_one", {48'h0, flushCnt_o}, 64'h1);
        chk("stats_stall_hold", {48'h0, stallCnt_o}, 64'hFFFF);
`endif

        step();
        chk("sb_empty", 64'(sb_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
